// File: rtl/machine_dir_seq.sv
// Sensor-driven direction sequencer: steps through NDIR directions on debounced
// end-of-travel sensors, with pause, direction reversal and a per-direction timeout fault.
module machine_dir_seq #(
  parameter int unsigned NDIR = 4,
  parameter int unsigned CW = 2,
  parameter int unsigned MW = 4,
  parameter logic [NDIR*CW-1:0] CTRL_TABLE = {2'd2, 2'd1, 2'd1, 2'd0},
  parameter logic [NDIR*MW-1:0] MOVE_TABLE = {4'd4, 4'd0, 4'd3, 4'd1},
  parameter int unsigned DEBOUNCE = 3,
  parameter int unsigned TIMEOUT = 255,
  localparam int unsigned IW = (NDIR > 2) ? $clog2(NDIR) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            dir_rev,
  input  logic            fault_clr,
  input  logic [NDIR-1:0] sensor,
  output logic [IW-1:0]   dir_idx,
  output logic [CW-1:0]   state_control,
  output logic [MW-1:0]   movement_sel,
  output logic            advance_pulse,
  output logic            fault
);

  localparam int unsigned DW = $clog2(DEBOUNCE + 1);
  localparam int unsigned TW = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_ADV   = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] dir_q, dir_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [CW-1:0] ctrl_q, ctrl_d;
  logic [MW-1:0] move_q, move_d;
  logic          adv_q, flt_q;

  logic          sens_c, deb_done_c, tmo_done_c;
  logic [IW-1:0] dir_next_c;
  int unsigned   sel_c;

  assign sens_c     = sensor[dir_q];
  assign deb_done_c = sens_c && (deb_q == DW'(DEBOUNCE - 1));
  assign tmo_done_c = (TIMEOUT != 0) && (tmo_q == TW'(TIMEOUT - 1));

  // Neighbouring direction with wrap-around in either order
  always_comb begin
    dir_next_c = dir_q + IW'(1);
    if (dir_rev) begin
      dir_next_c = (dir_q == '0) ? IW'(NDIR - 1) : dir_q - IW'(1);
    end else if (dir_q == IW'(NDIR - 1)) begin
      dir_next_c = '0;
    end
  end

  // Next-state logic; debounce completion takes priority over timeout
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    deb_d   = deb_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_IDLE: begin
        deb_d = '0;
        tmo_d = '0;
        if (en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!en) begin
          state_d = ST_IDLE;
          deb_d   = '0;
          tmo_d   = '0;
        end else begin
          if (deb_done_c) begin
            state_d = ST_ADV;
          end else if (tmo_done_c) begin
            state_d = ST_FAULT;
          end
          deb_d = sens_c ? deb_q + DW'(1) : '0;
          if (tmo_q != '1) tmo_d = tmo_q + TW'(1);
        end
      end
      ST_ADV: begin
        dir_d   = dir_next_c;
        deb_d   = '0;
        tmo_d   = '0;
        state_d = en ? ST_RUN : ST_IDLE;
      end
      ST_FAULT: begin
        if (fault_clr) begin
          state_d = ST_IDLE;
          deb_d   = '0;
          tmo_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output codes decoded from the next state so the registered outputs track the state register
  always_comb begin
    ctrl_d = '0;
    move_d = '0;
    sel_c  = 32'(dir_d);
    if (state_d == ST_RUN) begin
      ctrl_d = CTRL_TABLE[sel_c*CW +: CW];
      move_d = MOVE_TABLE[sel_c*MW +: MW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dir_q   <= '0;
      deb_q   <= '0;
      tmo_q   <= '0;
      ctrl_q  <= '0;
      move_q  <= '0;
      adv_q   <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      deb_q   <= deb_d;
      tmo_q   <= tmo_d;
      ctrl_q  <= ctrl_d;
      move_q  <= move_d;
      adv_q   <= (state_d == ST_ADV);
      flt_q   <= (state_d == ST_FAULT);
    end
  end

  assign dir_idx       = dir_q;
  assign state_control = ctrl_q;
  assign movement_sel  = move_q;
  assign advance_pulse = adv_q;
  assign fault         = flt_q;

endmodule

// File: tb/tb_machine_dir_seq.sv
// Bench for machine_dir_seq (TIMEOUT=10): vector table, corner sequences and
// random stimulus checked against a behavioural model of the sequencer.
module tb_machine_dir_seq;

  localparam int ND  = 4;
  localparam int DEB = 3;
  localparam int TMO = 10;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_ADV   = 2;
  localparam int M_FAULT = 3;

  logic       clk;
  logic       rst, en, dir_rev, fault_clr;
  logic [3:0] sensor;
  logic [1:0] dir_idx;
  logic [1:0] state_control;
  logic [3:0] movement_sel;
  logic       advance_pulse, fault;

  int checks = 0;
  int errors = 0;

  // Legacy encodings: UP, RIGHT, DOWN, LEFT
  int ctrl_lut[4] = '{0, 1, 1, 2};
  int move_lut[4] = '{1, 3, 0, 4};

  int m_mode = M_IDLE;
  int m_dir = 0;
  int m_streak = 0;
  int m_age = 0;

  typedef struct {
    logic       r, e, rv, c;
    logic [3:0] s;
    int         dir, ctrl, move, adv, flt;
  } vec_t;

  vec_t vecs[$];

  machine_dir_seq #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .en(en), .dir_rev(dir_rev), .fault_clr(fault_clr),
    .sensor(sensor), .dir_idx(dir_idx), .state_control(state_control),
    .movement_sel(movement_sel), .advance_pulse(advance_pulse), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one call per rising edge with the inputs sampled there
  task automatic model_step(input logic r, e, rv, c, input logic [3:0] s);
    if (r) begin
      m_mode = M_IDLE; m_dir = 0; m_streak = 0; m_age = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (e) begin m_mode = M_RUN; m_streak = 0; m_age = 0; end
        M_RUN: begin
          if (!e) begin
            m_mode = M_IDLE; m_streak = 0; m_age = 0;
          end else if (s[m_dir] && (m_streak + 1 == DEB)) begin
            m_mode = M_ADV;
          end else if (m_age + 1 == TMO) begin
            m_mode = M_FAULT;
          end else begin
            m_streak = s[m_dir] ? m_streak + 1 : 0;
            m_age++;
          end
        end
        M_ADV: begin
          m_dir = rv ? (m_dir + ND - 1) % ND : (m_dir + 1) % ND;
          m_streak = 0; m_age = 0;
          m_mode = e ? M_RUN : M_IDLE;
        end
        default: if (c) begin m_mode = M_IDLE; m_streak = 0; m_age = 0; end
      endcase
    end
  endtask

  task automatic apply(input logic r, e, rv, c, input logic [3:0] s);
    rst = r; en = e; dir_rev = rv; fault_clr = c; sensor = s;
    @(posedge clk);
    model_step(r, e, rv, c, s);
    #1;
    check("model_dir", 32'(dir_idx), 32'(m_dir));
    check("model_ctrl", 32'(state_control), (m_mode == M_RUN) ? 32'(ctrl_lut[m_dir]) : 32'd0);
    check("model_move", 32'(movement_sel), (m_mode == M_RUN) ? 32'(move_lut[m_dir]) : 32'd0);
    check("model_adv", 32'(advance_pulse), 32'(m_mode == M_ADV));
    check("model_fault", 32'(fault), 32'(m_mode == M_FAULT));
  endtask

  function automatic vec_t mkv(input logic r, e, rv, c, input logic [3:0] s,
                               input int d, ct, mv, a, f);
    vec_t v;
    v.r = r; v.e = e; v.rv = rv; v.c = c; v.s = s;
    v.dir = d; v.ctrl = ct; v.move = mv; v.adv = a; v.flt = f;
    return v;
  endfunction

  initial begin
    logic [3:0] rs;
    rst = 1'b1; en = 1'b0; dir_rev = 1'b0; fault_clr = 1'b0; sensor = '0;

    // Expected outputs after each edge: dir, ctrl, move, adv, fault
    vecs.push_back(mkv(1, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 4'b0000, 0, 0, 1, 0, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 4'b0001, 0, 0, 1, 0, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 4'b0001, 0, 0, 1, 0, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 4'b0000, 0, 0, 1, 0, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 4'b0001, 0, 0, 1, 0, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 4'b0001, 0, 0, 1, 0, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 4'b0001, 0, 0, 0, 1, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 4'b0011, 1, 1, 3, 0, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 4'b0011, 1, 1, 3, 0, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 4'b0011, 1, 1, 3, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 4'b0011, 1, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 4'b0010, 1, 1, 3, 0, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 4'b0010, 1, 1, 3, 0, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 4'b0010, 1, 1, 3, 0, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 4'b0010, 1, 0, 0, 1, 0));
    vecs.push_back(mkv(0, 1, 1, 0, 4'b0000, 0, 0, 1, 0, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 4'b0001, 0, 0, 1, 0, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 4'b0001, 0, 0, 1, 0, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 4'b0001, 0, 0, 0, 1, 0));
    vecs.push_back(mkv(0, 1, 1, 0, 4'b0000, 3, 2, 4, 0, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 4'b1000, 3, 2, 4, 0, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 4'b1000, 3, 2, 4, 0, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 4'b1000, 3, 0, 0, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      apply(vecs[i].r, vecs[i].e, vecs[i].rv, vecs[i].c, vecs[i].s);
      check($sformatf("v%0d_dir", i), 32'(dir_idx), 32'(vecs[i].dir));
      check($sformatf("v%0d_ctrl", i), 32'(state_control), 32'(vecs[i].ctrl));
      check($sformatf("v%0d_move", i), 32'(movement_sel), 32'(vecs[i].move));
      check($sformatf("v%0d_adv", i), 32'(advance_pulse), 32'(vecs[i].adv));
      check($sformatf("v%0d_fault", i), 32'(fault), 32'(vecs[i].flt));
    end

    // Timeout in direction 2, fault ignores en/sensor, fault_clr holds dir
    apply(1, 0, 0, 0, 4'b0000);
    apply(0, 1, 0, 0, 4'b0000);
    repeat (2) begin
      repeat (3) apply(0, 1, 0, 0, 4'b1111);
      apply(0, 1, 0, 0, 4'b0000);
    end
    check("tmo_start_dir", 32'(dir_idx), 32'd2);
    for (int k = 0; k < TMO - 1; k++) begin
      apply(0, 1, 0, 0, 4'b0000);
      check("tmo_pre_fault", 32'(fault), 32'd0);
    end
    apply(0, 1, 0, 0, 4'b0000);
    check("tmo_fault", 32'(fault), 32'd1);
    check("tmo_fault_ctrl", 32'(state_control), 32'd0);
    check("tmo_fault_move", 32'(movement_sel), 32'd0);
    for (int k = 0; k < 4; k++) begin
      apply(0, k[0], 0, 0, 4'b1111);
      check("fault_hold", 32'(fault), 32'd1);
    end
    apply(0, 1, 0, 1, 4'b0000);
    check("clr_fault", 32'(fault), 32'd0);
    check("clr_dir", 32'(dir_idx), 32'd2);
    check("clr_ctrl", 32'(state_control), 32'd0);
    apply(0, 1, 0, 0, 4'b0000);
    check("rerun_ctrl", 32'(state_control), 32'd1);
    check("rerun_move", 32'(movement_sel), 32'd0);

    // Debounce completes on the same edge the timeout would expire
    apply(1, 0, 0, 0, 4'b0000);
    apply(0, 1, 0, 0, 4'b0000);
    repeat (7) apply(0, 1, 0, 0, 4'b0000);
    repeat (2) apply(0, 1, 0, 0, 4'b0001);
    apply(0, 1, 0, 0, 4'b0001);
    check("collide_adv", 32'(advance_pulse), 32'd1);
    check("collide_fault", 32'(fault), 32'd0);

    // Reset while in ADVANCE
    apply(1, 1, 0, 0, 4'b0000);
    check("rst_adv_dir", 32'(dir_idx), 32'd0);
    check("rst_adv_pulse", 32'(advance_pulse), 32'd0);
    check("rst_adv_move", 32'(movement_sel), 32'd0);
    apply(0, 1, 0, 0, 4'b0000);
    check("rst_rerun_move", 32'(movement_sel), 32'd1);

    // Random stimulus against the model
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 4; b++) rs[b] = ($urandom_range(0, 9) < 6);
      apply($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
            1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
